grant_scheduler8: RTL and testbench
===================================

# grant_scheduler8

Round-robin scheduler that shares one 8-way resource among eight requesters and drives the one-hot grant lines selecting it. It sits in front of the 3-to-8 `decoder`: it computes a 3-bit winner index, expands it through `decoder` to a one-hot grant, and sequences grant hold, release and timeout preemption. A registered grant bus gives downstream logic a glitch-free, single-owner select.

## Interface
Parameters:
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per owner. A value of 0 disables the timeout.
- `HCW`, default `$clog2(MAX_HOLD+1)`: hold-counter width. It is derived and must not be overridden.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  scheduler enable. When low, no new grant issues and any current grant is withdrawn.
- `req`  in  8  request vector; bit i is requester i.
- `done`  in  1  current owner finished; sampled only in GRANT.
- `gnt`  out  8  registered one-hot grant; all zero when no owner.
- `gnt_valid`  out  1  registered; equals `|gnt`.
- `gnt_id`  out  3  registered index of the current owner; holds the last value when `gnt_valid`=0.
- `preempt`  out  1  registered one-cycle pulse when a grant is revoked by timeout.

## Operation
- Reset (async assert, sync-released at the next `clk`):
  - `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `preempt`=0.
  - state=IDLE, priority pointer `ptr`=0, hold counter=0.
- States: IDLE, GRANT.
- IDLE, entry condition: `enable`=1 and `req`≠0.
  - Winner = first set bit of `req` scanning upward from `ptr`, wrapping 7→0.
  - Register `gnt_id`=winner and `gnt`=decoder(winner) with decoder enable=1.
  - Set `gnt_valid`=1, hold counter=1, and go to GRANT.
- IDLE, no entry: outputs are 0 except `gnt_id`, which holds.
- GRANT, exit conditions (any one): `done`=1, `req[gnt_id]`=0, `enable`=0, or (`MAX_HOLD`≠0 and hold counter==`MAX_HOLD`).
  - On exit: `gnt`=0, `gnt_valid`=0, `ptr`=`gnt_id`+1 (mod 8), go to IDLE.
  - `preempt`=1 only when timeout is the sole exit cause. `done`, request drop and `enable` low take precedence and suppress `preempt`.
- GRANT, no exit: hold counter increments (saturating at `MAX_HOLD`). `gnt` and `gnt_id` stay stable.
- Other requests arriving during GRANT are ignored until IDLE. There is no mid-grant preemption other than timeout.
- `ptr` advances only on grant exit. A requester that is timed out goes to lowest priority.
- `req` bits that drop while not granted are simply not selected. There is no request latching.

## Timing
- Grant latency: `req` sampled high in IDLE at edge t → `gnt` high after edge t.
- Release latency: exit condition sampled at edge t → `gnt`=0 after edge t.
- At least one all-zero `gnt` cycle separates consecutive grants, so there is never overlap between owners. Back-to-back grant spacing is 1 idle cycle.
- Maximum continuous grant is `MAX_HOLD` cycles. Worst-case wait for a requester holding `req` is 7×(`MAX_HOLD`+1) cycles.
- `preempt` is high for exactly the IDLE cycle following a timeout exit.
- Asynchronous reset mid-grant clears `gnt` immediately, with no clock needed.
- Simultaneous `done` and timeout produces a normal exit with `preempt`=0.

## Structure
- Shared package `grant_pkg`:
  - state enum {IDLE, GRANT};
  - constant `NREQ`=8;
  - constant `IDW`=3.
- Sub-module: one `decoder` instance converts the next `gnt_id` to one-hot. Its output is registered into `gnt`; its enable is driven by the "issue grant" condition.
- The rotate-priority find-first logic is a local function. It is not a separate module.

## Test plan
- Reset mid-grant: owner 5 granted, pull `rst_n` low between edges → `gnt`=0, `gnt_valid`=0 immediately. After release with `req`=8'h01: `gnt`=8'h01 one cycle later (`ptr`=0).
- Round-robin rotation: `req`=8'hFF held, each owner asserts `done` on its 2nd grant cycle → `gnt_id` sequence 0,1,2,…,7,0, with one zero cycle between grants.
- Wrap and skip: `ptr`=6 (after owner 5 releases), `req`=8'h09 → `gnt_id`=0 (`gnt`=8'h01), then after release `gnt_id`=3.
- Timeout: `MAX_HOLD`=4, `req`=8'h04 steady, `done`=0 → `gnt`=8'h04 for exactly 4 cycles, then `preempt`=1 for 1 cycle. Re-granted to 2 after the idle cycle if it is the only requester.
- Enable and request drop: while owner 3 is granted, deassert `enable` → `gnt`=0 next cycle, `preempt`=0, no new grant while `enable`=0. Repeat with `req[3]` dropping → same release, `ptr`=4.
- Simultaneous `done` and timeout at hold count `MAX_HOLD` → release with `preempt`=0. Check `gnt` is always one-hot or zero across a random `req`/`done` run of 10k cycles.

Source files
------------

// File: rtl/grant_pkg.sv
// Shared types and constants for the 8-way round-robin grant scheduler.
package grant_pkg;

  localparam int unsigned NREQ = 8;
  localparam int unsigned IDW  = 3;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } state_e;

endpackage

// File: rtl/decoder.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module decoder
  import grant_pkg::*;
(
  input  logic            en,
  input  logic [IDW-1:0]  a,
  output logic [NREQ-1:0] y
);

  // Expand the index to a single hot bit when enabled.
  always_comb begin
    y = '0;
    if (en) begin
      y[a] = 1'b1;
    end
  end

endmodule

// File: rtl/grant_scheduler8.sv
// Round-robin scheduler for one shared 8-way resource: registered one-hot grant,
// done/request-drop/enable release and hold-limit timeout with a preempt pulse.
module grant_scheduler8
  import grant_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HCW      = $clog2(MAX_HOLD + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id,
  output logic            preempt
);

  // MAX_HOLD=0 yields a zero-width counter; keep at least one bit so the code stays legal.
  localparam int unsigned CW = (HCW == 0) ? 1 : HCW;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            gnt_valid_q;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic            preempt_q, preempt_d;

  logic            issue;
  logic [IDW-1:0]  winner;
  logic [NREQ-1:0] dec_y;
  logic            exit_norm;
  logic            timeout;

  // First set request at or above p, wrapping 7 -> 0; returns p when nothing is set.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDW-1:0]  p);
    logic [IDW-1:0] idx;
    logic           found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = p + IDW'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign winner = rr_pick(req, ptr_q);

  decoder u_decoder (
    .en (issue),
    .a  (winner),
    .y  (dec_y)
  );

  // Release causes; a normal release always masks the timeout as the reported cause.
  always_comb begin
    exit_norm = done | ~req[gnt_id_q] | ~enable;
    timeout   = (MAX_HOLD != 0) && (hold_q == CW'(MAX_HOLD));
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_id_d  = gnt_id_q;
    gnt_d     = '0;
    preempt_d = 1'b0;
    issue     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && (req != '0)) begin
          issue    = 1'b1;
          gnt_id_d = winner;
          gnt_d    = dec_y;
          hold_d   = CW'(1);
          state_d  = StGrant;
        end
      end
      StGrant: begin
        if (exit_norm || timeout) begin
          ptr_d     = gnt_id_q + IDW'(1);
          hold_d    = '0;
          preempt_d = timeout & ~exit_norm;
          state_d   = StIdle;
        end else begin
          gnt_d = gnt_q;
          if ((MAX_HOLD == 0) || (hold_q != CW'(MAX_HOLD))) begin
            hold_d = hold_q + CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; async reset clears the grant without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      hold_q      <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= |gnt_d;
      gnt_id_q    <= gnt_id_d;
      preempt_q   <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_grant_scheduler8.sv
// Directed plus random bench for grant_scheduler8 with a cycle scoreboard.
module tb_grant_scheduler8;

  localparam int unsigned MAXH = 4;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic       preempt;

  int checks;
  int passed;

  // Reference model state.
  logic       m_grant;
  logic [2:0] m_ptr;
  int         m_hold;
  logic [2:0] m_id;
  logic [7:0] m_gnt;
  logic       m_pre;

  logic [12:0] exp_q[$];

  grant_scheduler8 #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_grant = 1'b0;
    m_ptr   = 3'd0;
    m_hold  = 0;
    m_id    = 3'd0;
    m_gnt   = 8'h00;
    m_pre   = 1'b0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs, predict the registered outputs, then compare after the edge.
  task automatic step(input logic [7:0] r, input logic d, input logic e);
    logic        norm;
    logic        to;
    logic [2:0]  w;
    logic [2:0]  cand;
    logic [12:0] got;
    req    = r;
    done   = d;
    enable = e;
    m_pre  = 1'b0;
    if (!m_grant) begin
      m_gnt = 8'h00;
      if (e && (r != 8'h00)) begin
        w = m_ptr;
        for (int k = 7; k >= 0; k--) begin
          cand = m_ptr + 3'(k);
          if (r[cand]) w = cand;
        end
        m_grant = 1'b1;
        m_id    = w;
        m_hold  = 1;
        m_gnt   = 8'h00;
        m_gnt[w] = 1'b1;
      end
    end else begin
      norm = d || !r[m_id] || !e;
      to   = (m_hold == MAXH);
      if (norm || to) begin
        m_grant = 1'b0;
        m_ptr   = m_id + 3'd1;
        m_gnt   = 8'h00;
        m_pre   = to && !norm;
      end else begin
        m_hold++;
      end
    end
    exp_q.push_back({m_gnt, |m_gnt, m_id, m_pre});
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk("scoreboard", {19'd0, gnt, gnt_valid, gnt_id, preempt}, {19'd0, got});
    chk("onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  int cnt;

  initial begin
    checks = 0;
    passed = 0;
    rst_n  = 1'b0;
    enable = 1'b0;
    req    = 8'h00;
    done   = 1'b0;
    model_reset();
    #12;
    chk("reset_gnt", {24'd0, gnt}, 32'd0);
    chk("reset_valid", {31'd0, gnt_valid}, 32'd0);
    chk("reset_id", {29'd0, gnt_id}, 32'd0);
    chk("reset_preempt", {31'd0, preempt}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-grant clears the grant without a clock.
    step(8'h20, 1'b0, 1'b1);
    chk("grant5", {24'd0, gnt}, 32'h20);
    step(8'h20, 1'b0, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_gnt", {24'd0, gnt}, 32'd0);
    chk("async_rst_valid", {31'd0, gnt_valid}, 32'd0);
    #2;
    rst_n = 1'b1;
    step(8'h01, 1'b0, 1'b1);
    chk("post_rst_gnt", {24'd0, gnt}, 32'h01);
    step(8'h01, 1'b1, 1'b1);

    // Round-robin rotation from ptr=0 with done on the second grant cycle.
    @(posedge clk);
    #1;
    pulse_reset();
    for (int k = 0; k < 9; k++) begin
      step(8'hFF, 1'b0, 1'b1);
      chk("rr_id", {29'd0, gnt_id}, k % 8);
      step(8'hFF, 1'b0, 1'b1);
      step(8'hFF, 1'b1, 1'b1);
      chk("rr_gap", {24'd0, gnt}, 32'd0);
    end

    // Wrap and skip: ptr=6 after owner 5 releases.
    step(8'h20, 1'b0, 1'b1);
    step(8'h20, 1'b1, 1'b1);
    step(8'h09, 1'b0, 1'b1);
    chk("wrap_id", {29'd0, gnt_id}, 32'd0);
    chk("wrap_gnt", {24'd0, gnt}, 32'h01);
    step(8'h09, 1'b1, 1'b1);
    step(8'h09, 1'b0, 1'b1);
    chk("skip_id", {29'd0, gnt_id}, 32'd3);
    step(8'h09, 1'b1, 1'b1);

    // Timeout after MAXH cycles, then preempt pulse and re-grant.
    cnt = 0;
    for (int k = 0; k < MAXH + 1; k++) begin
      step(8'h04, 1'b0, 1'b1);
      if (gnt == 8'h04) cnt++;
    end
    chk("timeout_len", cnt, MAXH);
    chk("preempt_pulse", {31'd0, preempt}, 32'd1);
    step(8'h04, 1'b0, 1'b1);
    chk("preempt_clear", {31'd0, preempt}, 32'd0);
    chk("regrant", {24'd0, gnt}, 32'h04);
    step(8'h04, 1'b1, 1'b1);

    // Enable low withdraws the grant without preempt.
    step(8'h08, 1'b0, 1'b1);
    chk("grant3", {24'd0, gnt}, 32'h08);
    step(8'h08, 1'b0, 1'b0);
    chk("en_release", {24'd0, gnt}, 32'd0);
    chk("en_nopre", {31'd0, preempt}, 32'd0);
    step(8'h08, 1'b0, 1'b0);
    step(8'h08, 1'b0, 1'b0);
    chk("en_hold_off", {24'd0, gnt}, 32'd0);

    // Request drop releases and moves ptr to 4.
    step(8'h08, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    chk("drop_release", {24'd0, gnt}, 32'd0);
    step(8'hFF, 1'b0, 1'b1);
    chk("drop_ptr", {29'd0, gnt_id}, 32'd4);
    step(8'hFF, 1'b1, 1'b1);

    // Done coinciding with timeout is a normal release.
    for (int k = 0; k < MAXH; k++) step(8'h02, 1'b0, 1'b1);
    step(8'h02, 1'b1, 1'b1);
    chk("done_to_gnt", {24'd0, gnt}, 32'd0);
    chk("done_to_nopre", {31'd0, preempt}, 32'd0);

    // Random traffic against the scoreboard.
    for (int k = 0; k < 10000; k++) begin
      step(8'($urandom & $urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) != 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
